// File: rtl/gp9001_vram_arb.sv
// GP9001 CPU operation sequencer with 4-phase ACK, sharing one VRAM port
// between CPU register/RAM ops and the video fetch requester.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for an op level; highest-priority op is latched
// S_REG      | register/pointer op applied this cycle
// S_RAM_WAIT | CPU RAM op waiting for the VRAM port
// S_RAM_BUSY | CPU RAM access in flight on the port
// S_DONE     | ACK raised, held until every op level is low
module gp9001_vram_arb #(
    parameter int AW         = 14,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK96,
    input  logic          RESET96n,
    input  logic          OP_SELECT_REG,
    input  logic          OP_WRITE_REG,
    input  logic          OP_SET_RAM_PTR,
    input  logic          OP_WRITE_RAM,
    input  logic          OP_READ_RAM_H,
    input  logic          OP_READ_RAM_L,
    input  logic [15:0]   CPU_DIN,
    output logic          GP9001ACK,
    output logic [15:0]   CPU_DOUT,
    input  logic          LVBL,
    output logic [7:0]    REG_ADDR,
    output logic          REG_WE,
    output logic [15:0]   REG_DATA,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_ADDR,
    output logic          VID_ACK,
    output logic [15:0]   VID_DATA,
    output logic [AW-1:0] VRAM_ADDR,
    output logic [15:0]   VRAM_WDATA,
    output logic          VRAM_WE,
    input  logic [15:0]   VRAM_DIN
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [1:0]    LAT_INIT   = 2'(RAM_LAT);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [2:0] {S_IDLE, S_REG, S_RAM_WAIT, S_RAM_BUSY, S_DONE} state_t;
    typedef enum logic [2:0] {K_SEL, K_WREG, K_PTR, K_WRAM, K_RDH, K_RDL} op_t;

    state_t        state, state_nx;
    op_t           op_q, op_dec;
    logic          any_op, ram_op_sel, cpu_ram_pend;
    logic          port_free, port_done, cpu_wins, grant_cpu, grant_vid;
    logic          port_busy, port_cpu;
    logic [1:0]    lat_cnt;
    logic [SW-1:0] starve;
    logic [AW-1:0] ptr;

    always_comb begin
        any_op     = OP_SELECT_REG | OP_WRITE_REG | OP_SET_RAM_PTR |
                     OP_WRITE_RAM | OP_READ_RAM_H | OP_READ_RAM_L;
        ram_op_sel = any_op & ~(OP_SELECT_REG | OP_WRITE_REG | OP_SET_RAM_PTR);
        op_dec     = K_RDL;
        if (OP_SELECT_REG)       op_dec = K_SEL;
        else if (OP_WRITE_REG)   op_dec = K_WREG;
        else if (OP_SET_RAM_PTR) op_dec = K_PTR;
        else if (OP_WRITE_RAM)   op_dec = K_WRAM;
        else if (OP_READ_RAM_H)  op_dec = K_RDH;
    end

    // A RAM op still sitting in IDLE already counts as pending, so video
    // grants made while it is being latched are charged to starvation and
    // the port is held back for the CPU when the CPU would win.
    always_comb begin
        cpu_ram_pend = (state == S_RAM_WAIT) || (state == S_IDLE && ram_op_sel);
        port_done    = port_busy && (lat_cnt == 2'd0);
        port_free    = !port_busy || (lat_cnt == 2'd0);
        cpu_wins     = cpu_ram_pend && (!LVBL || (starve == STARVE_TOP) || !VID_REQ);
        grant_cpu    = port_free && cpu_wins && (state == S_RAM_WAIT);
        grant_vid    = port_free && VID_REQ && !cpu_wins;
    end

    always_ff @(posedge CLK96 or negedge RESET96n) begin
        if (!RESET96n) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (any_op) state_nx = ram_op_sel ? S_RAM_WAIT : S_REG;
            S_REG:      state_nx = S_DONE;
            S_RAM_WAIT: if (grant_cpu) state_nx = S_RAM_BUSY;
            S_RAM_BUSY: if (port_done && port_cpu) state_nx = S_DONE;
            S_DONE:     if (GP9001ACK && !any_op) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK96 or negedge RESET96n) begin
        if (!RESET96n) begin
            op_q       <= K_SEL;
            ptr        <= '0;
            starve     <= '0;
            port_busy  <= 1'b0;
            port_cpu   <= 1'b0;
            lat_cnt    <= 2'd0;
            GP9001ACK  <= 1'b0;
            CPU_DOUT   <= '0;
            REG_ADDR   <= '0;
            REG_WE     <= 1'b0;
            REG_DATA   <= '0;
            VID_ACK    <= 1'b0;
            VID_DATA   <= '0;
            VRAM_ADDR  <= '0;
            VRAM_WDATA <= '0;
            VRAM_WE    <= 1'b0;
        end else begin
            REG_WE    <= 1'b0;
            VID_ACK   <= 1'b0;
            VRAM_WE   <= grant_cpu && (op_q == K_WRAM);
            GP9001ACK <= (state == S_DONE) && !(GP9001ACK && !any_op);

            if (state == S_IDLE && any_op) op_q <= op_dec;

            if (state == S_REG) begin
                case (op_q)
                    K_SEL:   REG_ADDR <= CPU_DIN[7:0];
                    K_WREG: begin
                        REG_DATA <= CPU_DIN;
                        REG_WE   <= 1'b1;
                    end
                    K_PTR:   ptr <= CPU_DIN[AW-1:0];
                    default: ;
                endcase
            end

            if (grant_cpu) begin
                VRAM_ADDR <= ptr;
                port_busy <= 1'b1;
                port_cpu  <= 1'b1;
                if (op_q == K_WRAM) begin
                    VRAM_WDATA <= CPU_DIN;
                    lat_cnt    <= 2'd0;
                end else begin
                    lat_cnt    <= LAT_INIT;
                end
            end else if (grant_vid) begin
                VRAM_ADDR <= VID_ADDR;
                port_busy <= 1'b1;
                port_cpu  <= 1'b0;
                lat_cnt   <= LAT_INIT;
            end else if (port_done) begin
                port_busy <= 1'b0;
            end else if (port_busy) begin
                lat_cnt <= lat_cnt - 2'd1;
            end

            if (port_done) begin
                if (port_cpu) begin
                    if (op_q != K_WRAM) CPU_DOUT <= VRAM_DIN;
                    if (op_q != K_RDH)  ptr <= ptr + AW'(1);
                end else begin
                    VID_DATA <= VRAM_DIN;
                    VID_ACK  <= 1'b1;
                end
            end

            if (grant_cpu || !cpu_ram_pend)
                starve <= '0;
            else if (grant_vid && starve != STARVE_TOP)
                starve <= starve + SW'(1);
        end
    end

endmodule

// File: tb/tb_gp9001_vram_arb.sv
// Bench for gp9001_vram_arb: directed CPU ops and video requests against a
// 1-cycle-latency VRAM model; a monitor checks DUT events against a queue.
module tb_gp9001_vram_arb;
    localparam int AW = 14;

    localparam logic [5:0] M_SEL  = 6'b100000;
    localparam logic [5:0] M_WREG = 6'b010000;
    localparam logic [5:0] M_PTR  = 6'b001000;
    localparam logic [5:0] M_WRAM = 6'b000100;
    localparam logic [5:0] M_RDH  = 6'b000010;
    localparam logic [5:0] M_RDL  = 6'b000001;

    localparam logic [1:0] EV_ACK = 2'd0, EV_VID = 2'd1, EV_WR = 2'd2, EV_REGWE = 2'd3;

    logic          CLK96 = 1'b0;
    logic          RESET96n;
    logic [5:0]    ops;
    logic [15:0]   CPU_DIN;
    logic          GP9001ACK;
    logic [15:0]   CPU_DOUT;
    logic          LVBL;
    logic [7:0]    REG_ADDR;
    logic          REG_WE;
    logic [15:0]   REG_DATA;
    logic          VID_REQ;
    logic [AW-1:0] VID_ADDR;
    logic          VID_ACK;
    logic [15:0]   VID_DATA;
    logic [AW-1:0] VRAM_ADDR;
    logic [15:0]   VRAM_WDATA;
    logic          VRAM_WE;
    logic [15:0]   VRAM_DIN;

    gp9001_vram_arb #(.AW(AW), .RAM_LAT(1), .STARVE_MAX(8)) dut (
        .CLK96          (CLK96),
        .RESET96n       (RESET96n),
        .OP_SELECT_REG  (ops[5]),
        .OP_WRITE_REG   (ops[4]),
        .OP_SET_RAM_PTR (ops[3]),
        .OP_WRITE_RAM   (ops[2]),
        .OP_READ_RAM_H  (ops[1]),
        .OP_READ_RAM_L  (ops[0]),
        .CPU_DIN        (CPU_DIN),
        .GP9001ACK      (GP9001ACK),
        .CPU_DOUT       (CPU_DOUT),
        .LVBL           (LVBL),
        .REG_ADDR       (REG_ADDR),
        .REG_WE         (REG_WE),
        .REG_DATA       (REG_DATA),
        .VID_REQ        (VID_REQ),
        .VID_ADDR       (VID_ADDR),
        .VID_ACK        (VID_ACK),
        .VID_DATA       (VID_DATA),
        .VRAM_ADDR      (VRAM_ADDR),
        .VRAM_WDATA     (VRAM_WDATA),
        .VRAM_WE        (VRAM_WE),
        .VRAM_DIN       (VRAM_DIN)
    );

    always #5 CLK96 = ~CLK96;

    // VRAM model: unwritten words read as addr ^ 16'hC3A5, 1-cycle read latency.
    logic [15:0] mem      [0:(1<<AW)-1];
    bit          wr_valid [0:(1<<AW)-1];
    always @(posedge CLK96) begin
        if (VRAM_WE) begin
            mem[VRAM_ADDR]      <= VRAM_WDATA;
            wr_valid[VRAM_ADDR] <= 1'b1;
        end
        VRAM_DIN <= wr_valid[VRAM_ADDR] ? mem[VRAM_ADDR] : (16'(VRAM_ADDR) ^ 16'hC3A5);
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;
    ev_t exp_q[$];

    function automatic string kind_str(input logic [1:0] k);
        case (k)
            EV_ACK:  return "ack";
            EV_VID:  return "vid_ack";
            EV_WR:   return "vram_write";
            default: return "reg_we";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got a=%h d=%h, required no event", kind_str(k), a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.d !== d) begin
                n_fail++;
                $display("FAIL event_%s: got %s a=%h d=%h, required %s a=%h d=%h",
                         kind_str(e.kind), kind_str(k), a, d, kind_str(e.kind), e.a, e.d);
            end
        end
    endtask

    logic ack_prev = 1'b0;
    always @(negedge CLK96) begin
        if (RESET96n === 1'b1) begin
            if (VID_ACK)  observe(EV_VID, 16'h0000, VID_DATA);
            if (VRAM_WE)  observe(EV_WR, 16'(VRAM_ADDR), VRAM_WDATA);
            if (REG_WE)   observe(EV_REGWE, 16'h0000, REG_DATA);
            if (GP9001ACK && !ack_prev) observe(EV_ACK, {8'h00, REG_ADDR}, CPU_DOUT);
        end
        ack_prev = GP9001ACK;
    end

    task automatic check_zero(input string tag);
        check({tag, "_ack"},        32'(GP9001ACK),  32'd0);
        check({tag, "_cpu_dout"},   32'(CPU_DOUT),   32'd0);
        check({tag, "_reg_addr"},   32'(REG_ADDR),   32'd0);
        check({tag, "_reg_we"},     32'(REG_WE),     32'd0);
        check({tag, "_reg_data"},   32'(REG_DATA),   32'd0);
        check({tag, "_vid_ack"},    32'(VID_ACK),    32'd0);
        check({tag, "_vid_data"},   32'(VID_DATA),   32'd0);
        check({tag, "_vram_addr"},  32'(VRAM_ADDR),  32'd0);
        check({tag, "_vram_wdata"}, 32'(VRAM_WDATA), 32'd0);
        check({tag, "_vram_we"},    32'(VRAM_WE),    32'd0);
    endtask

    task automatic wait_ack(input string name, output int lat);
        lat = 0;
        while (GP9001ACK !== 1'b1 && lat < 100) begin
            @(posedge CLK96); #1;
            lat++;
        end
        check({name, "_ack_rise"}, 32'(GP9001ACK), 32'd1);
    endtask

    task automatic release_op(input string name, input int hold);
        repeat (hold) begin
            @(posedge CLK96); #1;
        end
        check({name, "_ack_hold"}, 32'(GP9001ACK), 32'd1);
        ops = '0;
        @(posedge CLK96); #1;
        check({name, "_ack_fall"}, 32'(GP9001ACK), 32'd0);
    endtask

    // Ops are raised 1 ns after an edge; a register op seen at the next edge
    // gives ACK two edges later, i.e. lat == 3 counting that first edge.
    task automatic cpu_op(input logic [5:0] m, input logic [15:0] din,
                          input int exp_lat, input int hold, input string name);
        int lat;
        CPU_DIN = din;
        ops     = m;
        wait_ack(name, lat);
        if (exp_lat > 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        release_op(name, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        RESET96n = 1'b0;
        ops      = '0;
        CPU_DIN  = '0;
        LVBL     = 1'b0;
        VID_REQ  = 1'b0;
        VID_ADDR = '0;
        repeat (3) @(posedge CLK96);
        #1;
        check_zero("in_reset");
        RESET96n = 1'b1;
        @(posedge CLK96); #1;
        check_zero("after_reset");

        expect_ev(EV_ACK, 16'h000E, 16'h0000);
        cpu_op(M_SEL, 16'h000E, 3, 2, "select");
        check("select_reg_addr", 32'(REG_ADDR), 32'h0E);

        // Pointer wrap: write at 0x3FFF, READ_L reads 0x0000, next write at 0x0001.
        expect_ev(EV_ACK, 16'h000E, 16'h0000);
        cpu_op(M_PTR, 16'h3FFF, 3, 0, "set_ptr_top");
        expect_ev(EV_WR,  16'h3FFF, 16'hABCD);
        expect_ev(EV_ACK, 16'h000E, 16'h0000);
        cpu_op(M_WRAM, 16'hABCD, 0, 0, "write_top");
        expect_ev(EV_ACK, 16'h000E, 16'hC3A5);
        cpu_op(M_RDL, 16'h0000, 0, 0, "read_l_wrap");
        expect_ev(EV_WR,  16'h0001, 16'h5555);
        expect_ev(EV_ACK, 16'h000E, 16'hC3A5);
        cpu_op(M_WRAM, 16'h5555, 0, 0, "write_after_inc");
        expect_ev(EV_ACK, 16'h000E, 16'hC3A5);
        cpu_op(M_PTR, 16'h3FFF, 0, 0, "set_ptr_top2");
        expect_ev(EV_ACK, 16'h000E, 16'hABCD);
        cpu_op(M_RDH, 16'h0000, 0, 0, "read_h_top");

        expect_ev(EV_REGWE, 16'h0000, 16'hBEEF);
        expect_ev(EV_ACK,   16'h000E, 16'hABCD);
        cpu_op(M_WREG, 16'hBEEF, 3, 0, "write_reg");
        check("write_reg_data", 32'(REG_DATA), 32'hBEEF);

        expect_ev(EV_ACK, 16'h0033, 16'hABCD);
        cpu_op(M_SEL | M_WREG, 16'h0033, 3, 0, "sel_over_wreg");
        check("sel_over_wreg_data", 32'(REG_DATA), 32'hBEEF);

        // Vertical blank: CPU read beats a video request raised the same cycle.
        expect_ev(EV_ACK, 16'h0033, 16'hABCD);
        cpu_op(M_PTR, 16'h0020, 0, 0, "set_ptr_20");
        expect_ev(EV_ACK, 16'h0033, 16'hC385);
        expect_ev(EV_VID, 16'h0000, 16'hC2A5);
        VID_ADDR = 14'h0100;
        CPU_DIN  = 16'h0000;
        ops      = M_RDH;
        VID_REQ  = 1'b1;
        repeat (4) @(posedge CLK96);
        #1;
        VID_REQ = 1'b0;
        wait_ack("vblank_read_h", lat);
        release_op("vblank_read_h", 0);
        check("vblank_cpu_dout", 32'(CPU_DOUT), 32'hC385);
        expect_ev(EV_WR,  16'h0020, 16'h7777);
        expect_ev(EV_ACK, 16'h0033, 16'hC385);
        cpu_op(M_WRAM, 16'h7777, 0, 0, "ptr_unchanged");

        // Active display: 8 video grants, then the starved CPU write, then video again.
        expect_ev(EV_ACK, 16'h0033, 16'hC385);
        cpu_op(M_PTR, 16'h0040, 0, 0, "set_ptr_40");
        LVBL     = 1'b1;
        VID_ADDR = 14'h0200;
        for (int i = 0; i < 8; i++) expect_ev(EV_VID, 16'h0000, 16'hC1A5);
        expect_ev(EV_WR,  16'h0040, 16'h1111);
        expect_ev(EV_ACK, 16'h0033, 16'hC385);
        expect_ev(EV_VID, 16'h0000, 16'hC1A5);
        CPU_DIN = 16'h1111;
        ops     = M_WRAM;
        VID_REQ = 1'b1;
        repeat (18) @(posedge CLK96);
        #1;
        VID_REQ = 1'b0;
        wait_ack("starve_write", lat);
        release_op("starve_write", 0);
        repeat (3) @(posedge CLK96);
        #1;
        check("starve_events_done", 32'(exp_q.size()), 32'd0);

        // Reset inside a video read's latency: no VID_ACK ever appears.
        VID_ADDR = 14'h0300;
        VID_REQ  = 1'b1;
        @(posedge CLK96);
        #2;
        RESET96n = 1'b0;
        VID_REQ  = 1'b0;
        repeat (3) @(posedge CLK96);
        #1;
        check_zero("mid_reset");
        RESET96n = 1'b1;
        LVBL     = 1'b0;
        repeat (4) @(posedge CLK96);
        #1;
        check_zero("post_abort");

        expect_ev(EV_ACK, 16'h0055, 16'h0000);
        cpu_op(M_SEL, 16'h0055, 3, 0, "select_after_reset");
        expect_ev(EV_WR,  16'h0000, 16'h9999);
        expect_ev(EV_ACK, 16'h0055, 16'h0000);
        cpu_op(M_WRAM, 16'h9999, 0, 0, "ptr_reset_write");

        repeat (5) @(posedge CLK96);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gp9001_vram_arb.md
Name: gp9001_vram_arb

Overview:
- Sequences the CPU-side GP9001 operation strobes and answers them with GP9001ACK.
- Operations handled: select register, write register, set VRAM pointer, write VRAM, read VRAM.
- Arbitrates the single VRAM port between those CPU accesses and the video tile/sprite fetch requester.
- Sits between the 68k glue (which holds op levels until ACK) and the GP9001 register file / VRAM.

Parameters:
AW, 14, VRAM word-address width (pointer and VID_ADDR width)
RAM_LAT, 1, VRAM read latency in cycles from issue to VRAM_DIN valid (1..3)
STARVE_MAX, 8, max consecutive video grants while a CPU RAM op waits during active display

Ports:
CLK96  in  1  system clock, all logic rising-edge
RESET96n  in  1  asynchronous active-low reset
OP_SELECT_REG  in  1  level, held until ACK seen
OP_WRITE_REG  in  1  level
OP_SET_RAM_PTR  in  1  level
OP_WRITE_RAM  in  1  level
OP_READ_RAM_H  in  1  level, read without pointer increment
OP_READ_RAM_L  in  1  level, read then pointer increment
CPU_DIN  in  16  CPU write data, stable while op high
GP9001ACK  out  1  op-complete handshake
CPU_DOUT  out  16  last VRAM read data
LVBL  in  1  1 = active display, 0 = vertical blank
REG_ADDR  out  8  selected register index
REG_WE  out  1  one-cycle register write strobe
REG_DATA  out  16  register write data
VID_REQ  in  1  video fetch request, level
VID_ADDR  in  AW  video fetch word address
VID_ACK  out  1  one-cycle pulse, VID_DATA valid
VID_DATA  out  16  video read data
VRAM_ADDR  out  AW  VRAM port address
VRAM_WDATA  out  16  VRAM write data
VRAM_WE  out  1  VRAM write enable
VRAM_DIN  in  16  VRAM read data

Behaviour:
Reset:
- All outputs 0, internal pointer 0, FSM in IDLE, starvation counter 0.

Handshake (4-phase):
- ACK rises when the op completes and stays high until all OP_* are low.
- ACK falls the cycle after that; a new op is accepted only from IDLE.

Simultaneous ops:
- Priority is SELECT_REG > WRITE_REG > SET_RAM_PTR > WRITE_RAM > READ_H > READ_L.
- Exactly one op is serviced per handshake.

CPU FSM states: IDLE, REG, RAM_WAIT, RAM_BUSY, DONE.

Register ops:
- SELECT_REG: REG_ADDR <= CPU_DIN[7:0] in REG; ACK in the next cycle (DONE).
- WRITE_REG: REG_DATA <= CPU_DIN and REG_WE = 1 for exactly one cycle, then DONE.
- SET_RAM_PTR: ptr <= CPU_DIN[AW-1:0], then DONE.
- Register-op latency: op high at edge N -> ACK high at edge N+2.

RAM ops:
- Sequence: RAM_WAIT until granted, then RAM_BUSY.
- Write: VRAM_ADDR = ptr, VRAM_WDATA = CPU_DIN, VRAM_WE = 1 for the issue cycle; ptr++ ; DONE.
- Read: VRAM_ADDR = ptr on issue; after RAM_LAT cycles capture VRAM_DIN into CPU_DOUT; READ_L then does ptr++ ; DONE.
- Pointer wraps 2^AW-1 -> 0.

Port occupancy:
- The port does one access at a time.
- A read occupies the port 1+RAM_LAT cycles; a write occupies 1 cycle.

Video path:
- Grant: VRAM_ADDR = VID_ADDR.
- After RAM_LAT cycles: VID_DATA <= VRAM_DIN and VID_ACK pulses for 1 cycle.
- If VID_REQ drops mid-access, the access still completes and VID_ACK still pulses.

Arbitration (evaluated when the port is free):
- LVBL = 0: CPU wins.
- LVBL = 1: video wins, unless the starvation counter == STARVE_MAX, in which case the CPU wins.
- The counter increments on each video grant while a CPU RAM op is pending.
- The counter clears on a CPU grant or when no CPU RAM op is pending.

Holding rules:
- CPU_DOUT, REG_ADDR and REG_DATA hold until next updated.
- VRAM_WE is never high outside a CPU write issue cycle.
- Async reset mid-access aborts it immediately; no ACK, VID_ACK or write is produced afterwards.

Test Plan:
- Reset, then SELECT_REG with CPU_DIN = 0x0E -> REG_ADDR = 0x0E, ACK high 2 cycles after op; ACK falls 1 cycle after op drops.
- SET_RAM_PTR 0x3FFF, then WRITE_RAM 0xABCD, then READ_RAM_L -> write at 0x3FFF; read at 0x0000 (wrapped); ptr becomes 0x0001.
- LVBL = 1, VID_REQ held continuously, CPU WRITE_RAM pending -> exactly 8 VID_ACKs, then the CPU write is granted, then video resumes.
- LVBL = 0, VID_REQ and READ_RAM_H arriving the same cycle -> CPU read issued first; CPU_DOUT = VRAM contents; ptr unchanged.
- WRITE_REG and SELECT_REG asserted together -> only the select is done; REG_WE stays 0.
- Assert RESET96n low during a video read's latency -> no VID_ACK; all outputs 0; FSM in IDLE after release.
